// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART receive control path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t c_ST_IDLE   = 3'd0;
    localparam rx_state_t c_ST_START  = 3'd1;
    localparam rx_state_t c_ST_DATA   = 3'd2;
    localparam rx_state_t c_ST_PARITY = 3'd3;
    localparam rx_state_t c_ST_STOP   = 3'd4;

    localparam logic c_PAR_EVEN = 1'b0;
    localparam logic c_PAR_ODD  = 1'b1;

    localparam int c_PRESCALE_8  = 8;
    localparam int c_PRESCALE_16 = 16;
    localparam int c_PRESCALE_32 = 32;

endpackage
`default_nettype wire

// File: rtl/data_sampling.sv
`default_nettype none
// ============================================================================
// Module   : data_sampling
// Brief    : Three-sample majority-vote bit sampler centred on the bit middle.
// Revision : 1.0 - initial release
// ============================================================================
module data_sampling #(
    parameter int SAMPLING_BITS = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_in,
    input  logic [SAMPLING_BITS-1:0] prescale,
    input  logic [SAMPLING_BITS-1:0] edge_cnt,
    input  logic                     enable,
    output logic                     sampled_bit
);

    localparam logic [SAMPLING_BITS-1:0] c_ONE = SAMPLING_BITS'(1);
    localparam logic [SAMPLING_BITS-1:0] c_TWO = SAMPLING_BITS'(2);

    logic [SAMPLING_BITS-1:0] w_mid;
    logic                     w_majority;
    logic [2:0]               r_samples;
    logic                     r_sampled_bit;

    assign w_mid      = prescale >> 1;
    assign w_majority = (r_samples[0] & r_samples[1]) |
                        (r_samples[0] & r_samples[2]) |
                        (r_samples[1] & r_samples[2]);

    // Vote is registered one edge after the last sample so it is stable at bit end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_samples     <= 3'b111;
            r_sampled_bit <= 1'b1;
        end else if (enable) begin
            if (edge_cnt == w_mid - c_ONE) r_samples[0] <= rx_in;
            if (edge_cnt == w_mid)         r_samples[1] <= rx_in;
            if (edge_cnt == w_mid + c_ONE) r_samples[2] <= rx_in;
            if (edge_cnt == w_mid + c_TWO) r_sampled_bit <= w_majority;
        end
    end

    assign sampled_bit = r_sampled_bit;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : UART receive frame FSM, deserializer and parity/stop checking.
//            UART_RX_SYNC_EN adds a 2-flop input synchronizer on rx_in.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int SAMPLING_BITS = 6,
    parameter int BIT_CNT_W     = 4,
    parameter int FRAME_DATA    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_in,
    input  logic [SAMPLING_BITS-1:0] prescale,
    input  logic                     par_en,
    input  logic                     par_typ,
    input  logic [SAMPLING_BITS-1:0] edge_cnt,
    input  logic [BIT_CNT_W-1:0]     bit_cnt,
    output logic                     cnt_enable,
    output logic [FRAME_DATA-1:0]    p_data,
    output logic                     data_valid,
    output logic                     par_err,
    output logic                     stp_err
);

    localparam logic [SAMPLING_BITS-1:0] c_ONE       = SAMPLING_BITS'(1);
    localparam logic [BIT_CNT_W-1:0]     c_LAST_DATA = BIT_CNT_W'(FRAME_DATA);

    rx_state_t             r_state;
    rx_state_t             w_next_state;
    logic                  w_rx;
    logic                  w_sampled;
    logic                  w_bit_end;
    logic                  w_start_entry;
    logic [FRAME_DATA-1:0] r_shift;
    logic [FRAME_DATA-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;
    logic                  r_par_en;
    logic                  r_par_typ;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], rx_in};
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = rx_in;
`endif

    data_sampling #(
        .SAMPLING_BITS (SAMPLING_BITS)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (w_rx),
        .prescale    (prescale),
        .edge_cnt    (edge_cnt),
        .enable      (cnt_enable),
        .sampled_bit (w_sampled)
    );

    assign w_bit_end     = cnt_enable && (edge_cnt == prescale - c_ONE);
    assign w_start_entry = (r_state == c_ST_IDLE) && !w_rx;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_start_entry) w_next_state = c_ST_START;
            c_ST_START:  if (w_bit_end) w_next_state = w_sampled ? c_ST_IDLE : c_ST_DATA;
            c_ST_DATA:   if (w_bit_end && (bit_cnt == c_LAST_DATA))
                             w_next_state = r_par_en ? c_ST_PARITY : c_ST_STOP;
            c_ST_PARITY: if (w_bit_end) w_next_state = c_ST_STOP;
            c_ST_STOP:   if (w_bit_end) w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_enable = (r_state != c_ST_IDLE);
    end

    // Frame options are frozen at start so a mid-frame change cannot corrupt checks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            r_par_en     <= 1'b0;
            r_par_typ    <= c_PAR_EVEN;
        end else begin
            r_data_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_entry) begin
                        r_par_err <= 1'b0;
                        r_stp_err <= 1'b0;
                        r_par_en  <= par_en;
                        r_par_typ <= par_typ;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) r_shift <= {w_sampled, r_shift[FRAME_DATA-1:1]};
                end
                c_ST_PARITY: begin
                    if (w_bit_end && ((^r_shift ^ r_par_typ) != w_sampled)) r_par_err <= 1'b1;
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        if (!w_sampled) begin
                            r_stp_err <= 1'b1;
                        end else if (!r_par_err) begin
                            r_p_data     <= r_shift;
                            r_data_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign p_data     = r_p_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive control path: frame FSM, 3-sample majority-vote bit sampler, deserializer, and parity/stop checks.
Sits directly downstream of edge_bit_counter. It drives the counter's enable and consumes its edge_cnt/bit_cnt.
Delivers a parallel byte plus a one-cycle data_valid to the ALU-side synchronizer.
All state is clocked by clk with synchronous active-high rst.

Parameters:
sampling_bits, 6, width of prescale/edge_cnt
bit_cnt_w, 4, width of bit_cnt
frame_data, 8, data bits per frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rx_in  input  1  serial line, idle high
prescale  input  sampling_bits  oversampling ratio; legal values 8, 16, 32; held stable while not IDLE
par_en  input  1  1 = parity bit present
par_typ  input  1  0 = even, 1 = odd
edge_cnt  input  sampling_bits  from edge_bit_counter
bit_cnt  input  bit_cnt_w  from edge_bit_counter
cnt_enable  output  1  enable to edge_bit_counter
p_data  output  frame_data  last good byte
data_valid  output  1  one-cycle pulse per good frame
par_err  output  1  parity error of last frame
stp_err  output  1  stop error of last frame

Behaviour:
- Reset: state IDLE, cnt_enable 0, p_data 0, data_valid 0, par_err 0, stp_err 0, shift register 0, sampled bit 1.
- cnt_enable = (state != IDLE), decoded from the state register.
- Bit-end event: edge_cnt == prescale-1 while cnt_enable = 1.
- Frame bit index: bit_cnt 0 = start; 1..frame_data = data, LSB first; next = parity (if par_en); last = stop.
- Sampler:
  - Captures rx_in at edge_cnt = prescale/2-1, prescale/2 and prescale/2+1.
  - Registers the majority value at edge_cnt = prescale/2+2.
  - All checks use this registered value at the bit-end event.
- IDLE: rx_in == 0 → START next cycle; counter begins at edge_cnt 0; par_err and stp_err clear on this transition.
- START, at bit-end:
  - sampled 1 → false start, return to IDLE, no flags set.
  - sampled 0 → DATA.
- DATA, at each bit-end:
  - shift register <= {sampled, shift[frame_data-1:1]}.
  - After bit_cnt == frame_data → PARITY if par_en, else STOP.
- PARITY, at bit-end:
  - expected = ^shift XOR par_typ.
  - Mismatch sets par_err. Go to STOP.
- STOP, at bit-end:
  - sampled 0 → stp_err = 1.
  - If no par_err and no stp_err: p_data <= shift, data_valid = 1 for exactly one cycle (the cycle after the bit-end).
  - Go to IDLE in all cases.
- On an error frame, p_data holds its previous value and data_valid stays 0.
- Error flags hold until the next START entry.
- Back-to-back frames: a start bit low in the first IDLE cycle after STOP is accepted, giving zero idle gap.
- par_en/par_typ are sampled at START entry and held internally for the whole frame.
- rst mid-frame forces IDLE on the next edge; cnt_enable drops, which zeroes the counter.

Optional Feature:
UART_RX_SYNC_EN:
- Defined: rx_in passes through a 2-flop synchronizer (reset value 1) before the FSM and sampler, adding 2 cycles of latency to start detection and all data_valid timing.
- Undefined: rx_in is used directly.

Decomposition:
- Package uart_pkg holds:
  - rx state typedef (IDLE, START, DATA, PARITY, STOP; binary encoded).
  - PAR_EVEN = 0, PAR_ODD = 1.
  - Legal prescale constants.
- One sub-module, data_sampling: the majority-vote sampler. Inputs clk, rst, rx_in, prescale, edge_cnt, enable; output sampled_bit.
- FSM, deserializer and checks stay in uart_rx_ctrl.

Test Plan:
- Frame 0xA5, prescale 8, par_en 0 → data_valid pulse once; p_data = 0xA5; par_err = 0; stp_err = 0.
- Frame 0x3C, prescale 16, par_en 1, par_typ 0, parity bit 0 → valid 0x3C. Repeat with parity bit 1 → par_err = 1, no data_valid, p_data unchanged.
- Stop bit driven 0 on frame 0x55 → stp_err = 1, no data_valid. Next good frame 0x12 → both flags clear, p_data = 0x12.
- rx_in low for 2 cycles then high, prescale 8 → FSM returns to IDLE after 8 cycles; no flags, no data_valid.
- Single-cycle glitch on the middle sample of data bit 3 of 0x00 → majority keeps 0; p_data = 0x00.
- rst asserted mid-DATA, then frame 0x81 → cnt_enable 0 the cycle after rst; clean receive of 0x81.
